nv_nvdla_pdp_in_sched: RTL and testbench

//  Layer sequencer and input arbiter in front of the PDP NaN/preproc stage. It picks one of two

---
 rtl/nv_nvdla_pdp_in_sched_pkg.sv | 27 ++
 rtl/nv_nvdla_pdp_in_sched_if.sv | 31 +++
 rtl/nv_nvdla_pdp_in_sched_pipe.sv | 53 +++++
 rtl/nv_nvdla_pdp_in_sched.sv | 148 ++++++++++++++
 tb/tb_nv_nvdla_pdp_in_sched.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nv_nvdla_pdp_in_sched_pkg.sv
// ============================================================================
// nv_nvdla_pdp_pkg : shared types and constants for the PDP input scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package nv_nvdla_pdp_pkg;

  localparam int          PDP_DW       = 46;
  localparam int          PDP_CEND_BIT = 45;
  localparam int          PDP_LEND_BIT = 41;
  localparam logic [31:0] CNT_SAT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // Counters stick at the maximum instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_SAT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nv_nvdla_pdp_in_sched_if.sv
// ============================================================================
// nv_nvdla_pdp_in_sched_if : SDP / RDMA source streams and preproc output stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface nv_nvdla_pdp_in_sched_if #(
  parameter int DW = nv_nvdla_pdp_pkg::PDP_DW
);
  logic          sdp2pdp_valid;
  logic          sdp2pdp_ready;
  logic [DW-1:0] sdp2pdp_pd;
  logic          rdma2pdp_valid;
  logic          rdma2pdp_ready;
  logic [DW-1:0] rdma2pdp_pd;
  logic          sched2pre_pvld;
  logic          sched2pre_prdy;
  logic [DW-1:0] sched2pre_pd;

  modport slave (
    input  sdp2pdp_valid, sdp2pdp_pd, rdma2pdp_valid, rdma2pdp_pd, sched2pre_prdy,
    output sdp2pdp_ready, rdma2pdp_ready, sched2pre_pvld, sched2pre_pd
  );

  modport master (
    output sdp2pdp_valid, sdp2pdp_pd, rdma2pdp_valid, rdma2pdp_pd, sched2pre_prdy,
    input  sdp2pdp_ready, rdma2pdp_ready, sched2pre_pvld, sched2pre_pd
  );
endinterface

`default_nettype wire

// File: rtl/nv_nvdla_pdp_in_sched_pipe.sv
// ============================================================================
// nv_nvdla_pdp_sched_pipe : single-entry valid/ready output register
// Rev 1.0
// ============================================================================
`default_nettype none

module nv_nvdla_pdp_sched_pipe
  import nv_nvdla_pdp_pkg::*;
#(
  parameter int DW = PDP_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_pd,
  output logic          o_in_rdy,
  output logic          o_vld,
  input  logic          i_out_rdy,
  output logic [DW-1:0] o_pd
);

  logic          vld_q, vld_d;
  logic [DW-1:0] pd_q,  pd_d;

  // Accepting while the held beat leaves keeps full throughput with no bubble.
  assign o_in_rdy = ~vld_q | i_out_rdy;
  assign o_vld    = vld_q;
  assign o_pd     = pd_q;

  always_comb begin
    vld_d = vld_q;
    pd_d  = pd_q;
    if (i_load) begin
      vld_d = 1'b1;
      pd_d  = i_pd;
    end else if (i_out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      pd_q  <= pd_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nv_nvdla_pdp_in_sched.sv
// ============================================================================
// nv_nvdla_pdp_in_sched : PDP layer sequencer and SDP/RDMA input arbiter
// Optional stall counter: PDP_SCHED_STALL_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module nv_nvdla_pdp_in_sched
  import nv_nvdla_pdp_pkg::*;
#(
  parameter int DW       = PDP_DW,
  parameter int CEND_BIT = PDP_CEND_BIT,
  parameter int LEND_BIT = PDP_LEND_BIT
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     reg2dp_op_en,
  input  logic                     reg2dp_flying_mode,
  input  logic                     dp2reg_done,
  nv_nvdla_pdp_in_sched_if.slave   io,
  output logic                     sched_busy,
  output logic [31:0]              dp2reg_beat_num,
  output logic [31:0]              dp2reg_stall_num
);

  sched_state_e  state_q, state_d;
  logic          op_en_d1_q;
  logic          mode_q, mode_d;
  logic          done_seen_q, done_seen_d;
  logic [31:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]   beat_num_q, beat_num_d;

  logic          w_arm;
  logic          w_sel_valid;
  logic [DW-1:0] w_sel_pd;
  logic          w_pipe_rdy;
  logic          w_sel_rdy;
  logic          w_accept;
  logic          w_layer_end;
  logic          w_drain_done;

  assign w_arm        = (state_q == ST_IDLE) & reg2dp_op_en & ~op_en_d1_q;
  assign w_sel_valid  = mode_q ? io.rdma2pdp_valid : io.sdp2pdp_valid;
  assign w_sel_pd     = mode_q ? io.rdma2pdp_pd    : io.sdp2pdp_pd;
  assign w_sel_rdy    = w_pipe_rdy & (state_q == ST_RUN);
  assign w_accept     = w_sel_valid & w_sel_rdy;
  assign w_layer_end  = w_sel_pd[CEND_BIT] & w_sel_pd[LEND_BIT];
  assign w_drain_done = (state_q == ST_DRAIN) & (done_seen_q | dp2reg_done) & ~io.sched2pre_pvld;

  assign io.sdp2pdp_ready  = ~mode_q & w_sel_rdy;
  assign io.rdma2pdp_ready =  mode_q & w_sel_rdy;
  assign sched_busy        = (state_q != ST_IDLE);
  assign dp2reg_beat_num   = beat_num_q;

  nv_nvdla_pdp_sched_pipe #(.DW(DW)) u_pipe (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .i_load    (w_accept),
    .i_pd      (w_sel_pd),
    .o_in_rdy  (w_pipe_rdy),
    .o_vld     (io.sched2pre_pvld),
    .i_out_rdy (io.sched2pre_prdy),
    .o_pd      (io.sched2pre_pd)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    done_seen_d = done_seen_q;
    beat_cnt_d  = beat_cnt_q;
    beat_num_d  = beat_num_q;

    if (w_accept) beat_cnt_d = sat_inc(beat_cnt_q);
    if (dp2reg_done && (state_q != ST_IDLE)) done_seen_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (w_arm) begin
          state_d     = ST_RUN;
          mode_d      = reg2dp_flying_mode;
          beat_cnt_d  = '0;
          done_seen_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_accept && w_layer_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_done) begin
          state_d    = ST_IDLE;
          beat_num_d = beat_cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= ST_IDLE;
      op_en_d1_q  <= 1'b0;
      mode_q      <= 1'b0;
      done_seen_q <= 1'b0;
      beat_cnt_q  <= '0;
      beat_num_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_en_d1_q  <= reg2dp_op_en;
      mode_q      <= mode_d;
      done_seen_q <= done_seen_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_num_q  <= beat_num_d;
    end
  end

`ifdef PDP_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] stall_num_q, stall_num_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_num_d = stall_num_q;
    if (w_arm) begin
      stall_cnt_d = '0;
    end else if (sched_busy && io.sched2pre_pvld && !io.sched2pre_prdy) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (w_drain_done) stall_num_d = stall_cnt_q;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt_q <= '0;
      stall_num_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_num_q <= stall_num_d;
    end
  end

  assign dp2reg_stall_num = stall_num_q;
`else
  assign dp2reg_stall_num = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nv_nvdla_pdp_in_sched.sv
// ============================================================================
// tb_nv_nvdla_pdp_in_sched : table-driven layers plus directed corner sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nv_nvdla_pdp_in_sched;
  import nv_nvdla_pdp_pkg::*;

  localparam int DW = PDP_DW;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        op_en = 1'b0;
  logic        fmode = 1'b0;
  logic        done  = 1'b0;
  logic        busy;
  logic [31:0] beat_num;
  logic [31:0] stall_num;

  nv_nvdla_pdp_in_sched_if #(.DW(DW)) bus ();

  nv_nvdla_pdp_in_sched dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .reg2dp_op_en       (op_en),
    .reg2dp_flying_mode (fmode),
    .dp2reg_done        (done),
    .io                 (bus),
    .sched_busy         (busy),
    .dp2reg_beat_num    (beat_num),
    .dp2reg_stall_num   (stall_num)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] mk_pd(input int unsigned tag, input bit last);
    logic [DW-1:0] p;
    p = '0;
    p[40:0] = 41'(tag);
    if (last) begin
      p[PDP_CEND_BIT] = 1'b1;
      p[PDP_LEND_BIT] = 1'b1;
    end else begin
      p[PDP_CEND_BIT] = tag[0];
      p[PDP_LEND_BIT] = ~tag[0] & tag[1];
    end
    return p;
  endfunction

  typedef struct {
    logic [DW-1:0] pd;
    int            cyc;
  } sb_t;

  sb_t           q[$];
  int            cyc = 0;
  bit            strict_lat = 1'b0;
  bit            cur_mode = 1'b0;
  int            wrong_rdy = 0;
  int            n_stall = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_pd = '0;
  int unsigned   tag_base = 32'h100;

  // Monitor samples 2 time units before each rising edge; the driver samples 1 unit later.
  always begin
    sb_t e;
    @(negedge clk);
    #3;
    if (rstn !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (prev_stall) begin
        chk("hold_vld", 64'(bus.sched2pre_pvld), 64'd1);
        chk("hold_pd",  64'(bus.sched2pre_pd),   64'(prev_pd));
      end
      if (bus.sched2pre_pvld && bus.sched2pre_prdy) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL out_unexpected: got pd %0h expected no beat", bus.sched2pre_pd);
        end else begin
          e = q.pop_front();
          chk("out_pd", 64'(bus.sched2pre_pd), 64'(e.pd));
          if (strict_lat) chk("latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
      if (bus.sdp2pdp_valid && bus.sdp2pdp_ready)   q.push_back('{bus.sdp2pdp_pd, cyc});
      if (bus.rdma2pdp_valid && bus.rdma2pdp_ready) q.push_back('{bus.rdma2pdp_pd, cyc});
      if (cur_mode ? bus.sdp2pdp_ready : bus.rdma2pdp_ready) wrong_rdy++;
      if (busy && bus.sched2pre_pvld && !bus.sched2pre_prdy) n_stall++;
      prev_stall = bus.sched2pre_pvld && !bus.sched2pre_prdy;
      prev_pd    = bus.sched2pre_pd;
    end
  end

  function automatic bit sel_rdy(input bit m);
    return m ? bus.rdma2pdp_ready : bus.sdp2pdp_ready;
  endfunction

  // The unused source always offers a layer-end beat that must never be taken.
  task automatic drive_src(input bit m, input logic [DW-1:0] pd, input bit v);
    if (m) begin
      bus.rdma2pdp_valid = v;  bus.rdma2pdp_pd = pd;
      bus.sdp2pdp_valid  = 1'b1; bus.sdp2pdp_pd = mk_pd(32'h1BAD0, 1'b1);
    end else begin
      bus.sdp2pdp_valid  = v;  bus.sdp2pdp_pd = pd;
      bus.rdma2pdp_valid = 1'b1; bus.rdma2pdp_pd = mk_pd(32'h2BAD0, 1'b1);
    end
  endtask

  task automatic src_idle();
    bus.sdp2pdp_valid  = 1'b0;
    bus.rdma2pdp_valid = 1'b0;
  endtask

  task automatic arm(input bit mode, input bit tog);
    cur_mode   = mode;
    strict_lat = !tog;
    wrong_rdy  = 0;
    @(negedge clk);
    fmode = mode;
    op_en = 1'b1;
    n_stall = 0;
    drive_src(mode, mk_pd(tag_base, 1'b0), 1'b1);
    #4;
    chk("idle_before_arm", 64'(busy), 64'd0);
  endtask

  task automatic run_layer(input bit mode, input int nb, input bit tog, input int ddly,
                           input bit done_last, input bit flip, input bit op_poke,
                           input int exp_beats);
    int acc = 0;
    int k = 0;
    int drain_rdy = 0;
    int j = 0;
    arm(mode, tog);
    while (acc < nb && k < 200) begin
      @(negedge clk);
      bus.sched2pre_prdy = tog ? k[0] : 1'b1;
      if (flip && k == 2) fmode = ~mode;
      op_en = op_poke ? k[1] : 1'b0;
      done  = done_last && (acc == nb - 1);
      drive_src(mode, mk_pd(tag_base + acc, acc == nb - 1), 1'b1);
      #4;
      if (k == 0) chk("busy_run", 64'(busy), 64'd1);
      if (sel_rdy(mode)) acc++;
      k++;
    end
    chk("accepted_beats", 64'(acc), 64'(nb));
    if (done_last) begin
      for (int d = 0; d < 3; d++) begin
        @(negedge clk);
        done = 1'b0;
        bus.sched2pre_prdy = 1'b1;
        drive_src(mode, mk_pd(tag_base + nb, 1'b0), 1'b1);
        #4;
        if (sel_rdy(mode)) drain_rdy++;
        chk("dl_busy", 64'(busy), (d < 2) ? 64'd1 : 64'd0);
        if (d < 2) chk("dl_pvld", 64'(bus.sched2pre_pvld), (d == 0) ? 64'd1 : 64'd0);
      end
    end else begin
      while (q.size() != 0 && j < 40) begin
        @(negedge clk);
        bus.sched2pre_prdy = 1'b1;
        drive_src(mode, mk_pd(tag_base + nb, 1'b0), 1'b1);
        #4;
        if (sel_rdy(mode)) drain_rdy++;
        j++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      for (int d = 0; d < ddly; d++) begin
        @(negedge clk);
        op_en = op_poke ? (d != 0) : 1'b0;
        #4;
        if (sel_rdy(mode)) drain_rdy++;
      end
      @(negedge clk);
      if (op_poke) op_en = 1'b1;
      done = 1'b1;
      #4;
      chk("busy_at_done", 64'(busy), 64'd1);
      @(negedge clk);
      done = 1'b0;
      #4;
      chk("idle_after_done", 64'(busy), 64'd0);
      if (op_poke) begin
        for (int d = 0; d < 2; d++) begin
          @(negedge clk);
          #4;
          chk("no_queued_arm", 64'(busy), 64'd0);
        end
        op_en = 1'b0;
      end
    end
    src_idle();
    chk("beat_num",   64'(beat_num),  64'(exp_beats));
    chk("drain_rdy",  64'(drain_rdy), 64'd0);
    chk("wrong_rdy",  64'(wrong_rdy), 64'd0);
    chk("sb_empty",   64'(q.size()),  64'd0);
`ifdef PDP_SCHED_STALL_CNT_EN
    chk("stall_num",  64'(stall_num), 64'(n_stall));
`else
    chk("stall_num",  64'(stall_num), 64'd0);
`endif
    tag_base += 32'h100;
  endtask

  typedef struct {
    bit mode;
    int nb;
    bit tog;
    int ddly;
    bit flip;
    int exp_beats;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [31:0] keep_num;
    int acc;
    int k;

    vt[0] = '{mode: 1'b1, nb: 8,  tog: 1'b0, ddly: 3, flip: 1'b0, exp_beats: 8};
    vt[1] = '{mode: 1'b0, nb: 16, tog: 1'b1, ddly: 2, flip: 1'b0, exp_beats: 16};
    vt[2] = '{mode: 1'b1, nb: 5,  tog: 1'b1, ddly: 1, flip: 1'b1, exp_beats: 5};
    vt[3] = '{mode: 1'b0, nb: 1,  tog: 1'b0, ddly: 0, flip: 1'b0, exp_beats: 1};

    bus.sched2pre_prdy = 1'b1;
    src_idle();
    bus.sdp2pdp_pd  = '0;
    bus.rdma2pdp_pd = '0;

    repeat (2) @(negedge clk);
    #4;
    chk("rst_pvld",      64'(bus.sched2pre_pvld), 64'd0);
    chk("rst_busy",      64'(busy),               64'd0);
    chk("rst_beat_num",  64'(beat_num),           64'd0);
    chk("rst_stall_num", 64'(stall_num),          64'd0);
    chk("rst_sdp_rdy",   64'(bus.sdp2pdp_ready),  64'd0);
    chk("rst_rdma_rdy",  64'(bus.rdma2pdp_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 4; i++)
      run_layer(vt[i].mode, vt[i].nb, vt[i].tog, vt[i].ddly, 1'b0, vt[i].flip, 1'b0,
                vt[i].exp_beats);

    // done while idle must neither start a layer nor touch the beat count
    keep_num = beat_num;
    @(negedge clk); done = 1'b1; #4;
    @(negedge clk); done = 1'b0; #4;
    chk("idle_done_busy", 64'(busy),     64'd0);
    chk("idle_done_num",  64'(beat_num), 64'(keep_num));

    // op_en re-pulsed during RUN and DRAIN
    run_layer(1'b0, 10, 1'b0, 4, 1'b0, 1'b0, 1'b1, 10);

    // layer end and done in the same cycle
    run_layer(1'b1, 4, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4);

    // asynchronous reset in the middle of a layer
    arm(1'b1, 1'b1);
    acc = 0;
    k = 0;
    while (acc < 5 && k < 100) begin
      @(negedge clk);
      op_en = 1'b0;
      bus.sched2pre_prdy = k[0];
      drive_src(1'b1, mk_pd(tag_base + acc, 1'b0), 1'b1);
      #4;
      if (sel_rdy(1'b1)) acc++;
      k++;
    end
    chk("pre_rst_beats", 64'(acc), 64'd5);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_pvld",     64'(bus.sched2pre_pvld), 64'd0);
    chk("mid_rst_busy",     64'(busy),               64'd0);
    chk("mid_rst_beat_num", 64'(beat_num),           64'd0);
    chk("mid_rst_rdma_rdy", 64'(bus.rdma2pdp_ready), 64'd0);
    q.delete();
    src_idle();
    op_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tag_base += 32'h100;
    run_layer(1'b0, 6, 1'b0, 1, 1'b0, 1'b0, 1'b0, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
